calc_arbiter: RTL and testbench
===============================

# calc_arbiter

Sequences the shared multi-cycle calculator core between two requesters (A and B). It captures one requester's operands, issues a one-cycle start to the core, and waits for `done_calc`. It then returns `ans` on `out` with a one-cycle done pulse to the owning requester. It sits between the input front-ends and the calculator core, and replaces direct wiring of `done_calc`/`ans` to the output stage.

## Interface
- `WIDTH`, 10: operand and result width.
- `TIMEOUT`, 15: maximum WAIT cycles before the operation is aborted with `err`; legal range 2..255.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `req_a`, `req_b`  in  1  request level; held high until the matching grant.
- `op_a`, `op_b`  in  2  operation code for the core.
- `x_a`, `y_a`, `x_b`, `y_b`  in  WIDTH  operands.
- `done_calc`  in  1  core completion strobe.
- `ans`  in  WIDTH  core result; valid while `done_calc` is high.
- `calc_start`  out  1  one-cycle start strobe to the core.
- `calc_op`  out  2  registered opcode to the core.
- `calc_x`, `calc_y`  out  WIDTH  registered operands to the core; stable from ISSUE through RESP.
- `grant_a`, `grant_b`  out  1  one-cycle operand-capture acknowledge.
- `out`  out  WIDTH  last result; holds its value between operations.
- `done_a`, `done_b`  out  1  one-cycle completion pulse to the owner.
- `err`  out  1  one-cycle timeout flag, coincident with the owner's done pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- `owner` register: identifies the current requester.
- `last` register: identifies the last granted requester; reset value is B, so A wins the first tie.
- IDLE, neither request high: stay in IDLE.
- IDLE, exactly one request high: that requester becomes `owner`.
- IDLE, both requests high: the requester other than `last` becomes `owner` (round-robin).
- On the transition into ISSUE, the owner's op/x/y are captured into `calc_op`/`calc_x`/`calc_y`, and `last` is set to `owner`.
- ISSUE: `calc_start`=1 and the owner's grant=1, both for exactly this cycle. Next state is WAIT, with the wait counter cleared to 0.
- WAIT, `done_calc`=1: `out` <= `ans`, the err flag is cleared, next state is RESP.
- WAIT, `done_calc`=0 and counter = TIMEOUT-1: the err flag is set, `out` is unchanged, next state is RESP.
- WAIT, otherwise: the counter increments. The counter is 8-bit and never wraps because TIMEOUT ≤ 255.
- `done_calc` and timeout on the same edge: `done_calc` wins, the result is taken and `err` stays 0.
- RESP: the owner's done pulse is 1; `err` is 1 only if the operation timed out. Next state is IDLE.
- `done_calc` outside WAIT is ignored, including a late strobe after a timeout or after reset.
- `req_x` is sampled only in IDLE. A request still high when IDLE is re-entered is treated as a new request.
- All outputs are decoded from registered state, with no combinational path from inputs to outputs.

## Timing
- Reset values: `out`=0, `calc_op`/`calc_x`/`calc_y`=0, all strobes (`calc_start`, grants, dones, `err`)=0, `busy`=0, state=IDLE, `last`=B.
- Reset asserted mid-operation: at the next edge the block returns to IDLE with all reset values. The in-flight result is discarded.
- A request sampled at edge k:
  - ISSUE during cycle k+1 (`grant`, `calc_start`).
  - WAIT from cycle k+2.
- `done_calc` sampled at edge m:
  - RESP during cycle m+1 (`done_x` pulse, `out` valid).
  - IDLE during cycle m+2.
- A core with 1-cycle latency (`done_calc` high in the first WAIT cycle) gives 4 cycles per operation, request-sample to next request-sample. This is the maximum throughput.
- Timeout: with no `done_calc`, RESP with `err` occurs TIMEOUT cycles after entry to WAIT.
- `out` changes only on the edge entering RESP after a successful completion.

## Test plan
- Single request: reset, then `req_a`=1 with op=2, x=100, y=23. Required response:
  - `grant_a` and `calc_start` high for one cycle, with `calc_x`=100, `calc_y`=23.
  - Core returns `ans`=123 after 3 cycles.
  - `out`=123, `done_a` high exactly 1 cycle, `done_b`=0, `err`=0.
- Tie after reset: `req_a`=`req_b`=1 held continuously. Grants alternate A, B, A, B over 4 operations, with `done_a`/`done_b` alternating to match.
- Timeout: `req_b`=1 and the core never asserts `done_calc`, TIMEOUT=15. Required response:
  - `done_b` and `err` high together, 15 cycles after WAIT entry.
  - `out` keeps its previous value (123).
  - A late `done_calc` afterwards has no effect.
- Race at timeout: `done_calc` with `ans`=0x3FF on the same edge as counter = 14. Required response: `out`=0x3FF, `err`=0.
- Reset mid-operation: assert `reset` in WAIT. Required response:
  - All outputs return to zero and the block enters IDLE.
  - A following `done_calc` is ignored.
  - Next request: tie goes to A.
- Stray `done_calc` in IDLE, ISSUE and RESP: no change to `out` and no done pulses.

Source files
------------

// File: rtl/calc_arbiter.sv
// calc_arbiter
//
// Shares one multi-cycle calculator core between two requesters (A and B).
// A request is accepted in IDLE (round-robin on a tie), and the owner's
// operands are captured. The block then issues a one-cycle start to the core
// and waits for done_calc or a timeout. The result goes back on `out`, with a
// one-cycle done pulse to the owner.
//
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   req_a/req_b              request levels, held until granted
//   op_a/op_b, x_*/y_*       per-requester opcode and operands
//   done_calc, ans           core completion strobe and result
//   calc_start               one-cycle start strobe to the core
//   calc_op/calc_x/calc_y    registered command to the core
//   grant_a/grant_b          one-cycle operand-capture acknowledge
//   out                      last successful result (held between operations)
//   done_a/done_b            one-cycle completion pulse to the owner
//   err                      one-cycle timeout flag, coincident with done_x
//   busy                     high whenever not in IDLE
module calc_arbiter #(
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [1:0]       op_a,
    input  logic [1:0]       op_b,
    input  logic [WIDTH-1:0] x_a,
    input  logic [WIDTH-1:0] y_a,
    input  logic [WIDTH-1:0] x_b,
    input  logic [WIDTH-1:0] y_b,
    input  logic             done_calc,
    input  logic [WIDTH-1:0] ans,
    output logic             calc_start,
    output logic [1:0]       calc_op,
    output logic [WIDTH-1:0] calc_x,
    output logic [WIDTH-1:0] calc_y,
    output logic             grant_a,
    output logic             grant_b,
    output logic [WIDTH-1:0] out,
    output logic             done_a,
    output logic             done_b,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       SEL_A    = 1'b0;
    localparam logic       SEL_B    = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       last;
    logic       err_flag;
    logic [7:0] wait_cnt;
    logic       pick;
    logic       timeout_hit;

    // Requester that wins in IDLE: the one not served last on a tie.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        pick = SEL_A;
        if (req_a && req_b) pick = ~last;
        else if (req_b)     pick = SEL_B;
    end

    assign timeout_hit = (wait_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking (<=) so every register sees
        // pre-edge values; blocking here would create order-dependent races.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_a || req_b) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (done_calc || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, wait counter, result and error flag.
    // done_calc is looked at only in WAIT, so stray or late strobes are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner    <= SEL_A;
            last     <= SEL_B;
            calc_op  <= '0;
            calc_x   <= '0;
            calc_y   <= '0;
            out      <= '0;
            err_flag <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner   <= pick;
                        last    <= pick;
                        calc_op <= (pick == SEL_B) ? op_b : op_a;
                        calc_x  <= (pick == SEL_B) ? x_b  : x_a;
                        calc_y  <= (pick == SEL_B) ? y_b  : y_a;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    // A completion on the timeout cycle takes priority.
                    if (done_calc) begin
                        out      <= ans;
                        err_flag <= 1'b0;
                    end else if (timeout_hit) begin
                        err_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        calc_start = (state == ISSUE);
        grant_a    = (state == ISSUE) && (owner == SEL_A);
        grant_b    = (state == ISSUE) && (owner == SEL_B);
        done_a     = (state == RESP)  && (owner == SEL_A);
        done_b     = (state == RESP)  && (owner == SEL_B);
        err        = (state == RESP)  && err_flag;
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Testbench for calc_arbiter. The stimulus driver pushes the expected grant
// and completion of each operation into queues. The monitor pops and compares
// them whenever the DUT shows a grant or a done pulse.
module tb_calc_arbiter;

    localparam int WIDTH   = 10;
    localparam int TIMEOUT = 15;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_a = 1'b0, req_b = 1'b0;
    logic [1:0]       op_a = '0, op_b = '0;
    logic [WIDTH-1:0] x_a = '0, y_a = '0, x_b = '0, y_b = '0;
    logic             done_calc = 1'b0;
    logic [WIDTH-1:0] ans = '0;
    logic             calc_start;
    logic [1:0]       calc_op;
    logic [WIDTH-1:0] calc_x, calc_y;
    logic             grant_a, grant_b;
    logic [WIDTH-1:0] out;
    logic             done_a, done_b, err, busy;

    calc_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .op_a(op_a), .op_b(op_b),
        .x_a(x_a), .y_a(y_a), .x_b(x_b), .y_b(y_b),
        .done_calc(done_calc), .ans(ans),
        .calc_start(calc_start), .calc_op(calc_op),
        .calc_x(calc_x), .calc_y(calc_y),
        .grant_a(grant_a), .grant_b(grant_b),
        .out(out), .done_a(done_a), .done_b(done_b),
        .err(err), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit               who;   // 0 = A, 1 = B
        logic [1:0]       op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } grant_exp_t;

    typedef struct {
        bit               who;
        logic [WIDTH-1:0] res;
        bit               err;
    } done_exp_t;

    grant_exp_t       gq[$];
    done_exp_t        dq[$];
    int               checks = 0;
    int               errors = 0;
    bit               m_last = 1'b1;   // model: last granted requester (B)
    logic [WIDTH-1:0] m_out  = '0;     // model: value `out` should hold

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents a grant or done.
    always @(negedge clock) begin : monitor
        grant_exp_t g;
        done_exp_t  d;
        if (!reset) begin
            check("start_with_grant", {31'd0, calc_start}, {31'd0, grant_a | grant_b});
            check("err_only_with_done", {31'd0, err & ~(done_a | done_b)}, 32'd0);
            if (grant_a || grant_b) begin
                checks++;
                if (gq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant: grant_a=%0b grant_b=%0b, none expected at %0t",
                             grant_a, grant_b, $time);
                end else begin
                    g = gq.pop_front();
                    check("grant_a", {31'd0, grant_a}, {31'd0, ~g.who});
                    check("grant_b", {31'd0, grant_b}, {31'd0, g.who});
                    check("calc_op", {30'd0, calc_op}, {30'd0, g.op});
                    check("calc_x", {22'd0, calc_x}, {22'd0, g.x});
                    check("calc_y", {22'd0, calc_y}, {22'd0, g.y});
                end
            end
            if (done_a || done_b) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done_a=%0b done_b=%0b, none expected at %0t",
                             done_a, done_b, $time);
                end else begin
                    d = dq.pop_front();
                    check("done_a", {31'd0, done_a}, {31'd0, ~d.who});
                    check("done_b", {31'd0, done_b}, {31'd0, d.who});
                    check("out", {22'd0, out}, {22'd0, d.res});
                    check("err", {31'd0, err}, {31'd0, d.err});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, {22'd0, out}, 32'd0);
        check({tag, "_calc_x"}, {22'd0, calc_x}, 32'd0);
        check({tag, "_calc_y"}, {22'd0, calc_y}, 32'd0);
        check({tag, "_calc_op"}, {30'd0, calc_op}, 32'd0);
        check({tag, "_strobes"}, {25'd0, calc_start, grant_a, grant_b, done_a, done_b, err, busy}, 32'd0);
    endtask

    task automatic rand_operands();
        op_a = 2'($urandom); x_a = WIDTH'($urandom); y_a = WIDTH'($urandom);
        op_b = 2'($urandom); x_b = WIDTH'($urandom); y_b = WIDTH'($urandom);
    endtask

    // One operation. Called at a negedge with the DUT in IDLE; returns at a
    // negedge with the DUT back in IDLE. lat = WAIT cycle index (0-based) at
    // which the core answers; lat >= TIMEOUT means the core never answers.
    task automatic do_op(input bit ra, input bit rb, input bit hold, input int lat,
                         input bit stray, input bit rst_mid, input logic [WIDTH-1:0] ans_v);
        bit         who;
        int         n;
        grant_exp_t g;
        done_exp_t  d;
        req_a = req_a | ra;
        req_b = req_b | rb;
        // Reference arbitration: tie goes to the requester not served last.
        if (req_a && req_b) who = ~m_last;
        else                who = req_b;
        m_last = who;
        g.who = who;
        g.op  = who ? op_b : op_a;
        g.x   = who ? x_b  : x_a;
        g.y   = who ? y_b  : y_a;
        gq.push_back(g);
        if (!rst_mid) begin
            d.who = who;
            if (lat < TIMEOUT) begin
                d.res = ans_v; d.err = 1'b0; m_out = ans_v;
            end else begin
                d.res = m_out; d.err = 1'b1;
            end
            dq.push_back(d);
        end

        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(grant_a || grant_b) && n < 8);
        check("grant_latency", n, 1);
        if (!(grant_a || grant_b)) return;
        if (!hold) begin
            if (who) req_b = 1'b0;
            else     req_a = 1'b0;
        end
        if (stray) begin   // strobe seen by the DUT during ISSUE: must be ignored
            done_calc = 1'b1;
            ans = WIDTH'($urandom);
        end
        @(negedge clock);  // first WAIT cycle
        done_calc = 1'b0;

        if (rst_mid) begin
            repeat (3) @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            check_all_zero("mid_reset");
            reset = 1'b0;
            req_a = 1'b0;
            req_b = 1'b0;
            done_calc = 1'b1;
            ans = WIDTH'($urandom);
            @(negedge clock);
            done_calc = 1'b0;
            check("post_reset_out", {22'd0, out}, 32'd0);
            check("post_reset_busy", {31'd0, busy}, 32'd0);
            m_last = 1'b1;
            m_out  = '0;
            return;
        end

        if (lat < TIMEOUT) begin
            repeat (lat) @(negedge clock);
            done_calc = 1'b1;
            ans = ans_v;
            @(negedge clock);
            done_calc = 1'b0;
            check("resp_after_done", {31'd0, done_a | done_b}, 32'd1);
        end else begin
            repeat (TIMEOUT) @(negedge clock);
            check("timeout_resp", {30'd0, done_a | done_b, err}, 32'd3);
        end

        if (stray) begin   // late strobe during RESP
            done_calc = 1'b1;
            ans = WIDTH'($urandom);
        end
        @(negedge clock);  // back in IDLE
        done_calc = 1'b0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("out_hold", {22'd0, out}, {22'd0, m_out});
        if (stray && !req_a && !req_b) begin   // strobe while idle
            done_calc = 1'b1;
            ans = WIDTH'($urandom);
            @(negedge clock);
            done_calc = 1'b0;
            check("idle_stray_out", {22'd0, out}, {22'd0, m_out});
            check("idle_stray_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ra, rb;
        int lat;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check("after_reset_busy", {31'd0, busy}, 32'd0);

        // Tie after reset, held continuously: A, B, A, B.
        for (int i = 0; i < 4; i++) begin
            rand_operands();
            do_op(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, WIDTH'($urandom));
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clock);

        // Single request: op=2, x=100, y=23, core answers 123 after 3 cycles.
        op_a = 2'd2; x_a = WIDTH'(100); y_a = WIDTH'(23);
        do_op(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, WIDTH'(123));

        // Timeout on B with late strobes; out keeps 123.
        rand_operands();
        do_op(1'b0, 1'b1, 1'b0, TIMEOUT, 1'b1, 1'b0, '0);
        check("timeout_keeps_out", {22'd0, out}, 32'd123);

        // Race: completion on the same edge as the final wait count.
        rand_operands();
        do_op(1'b1, 1'b0, 1'b0, TIMEOUT - 1, 1'b0, 1'b0, WIDTH'(10'h3FF));
        check("race_out", {22'd0, out}, 32'h3FF);

        // Stray strobes in ISSUE, RESP and IDLE around a normal operation.
        rand_operands();
        do_op(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, WIDTH'($urandom));

        // Reset while in WAIT, then a tie must go to A.
        rand_operands();
        do_op(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, '0);
        rand_operands();
        do_op(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, WIDTH'($urandom));

        // Randomized traffic; an ungranted requester keeps its request high.
        for (int i = 0; i < 40; i++) begin
            rand_operands();
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb && !req_a && !req_b) ra = 1'b1;
            lat = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
            do_op(ra, rb, 1'b0, lat, 1'($urandom), 1'b0, WIDTH'($urandom));
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(negedge clock);
        check("grant_queue_empty", gq.size(), 0);
        check("done_queue_empty", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
